// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encodings and a
// width helper usable in constant expressions.
package arb_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'b001,
        ST_GNT  = 3'b010,
        ST_GAP  = 3'b100
    } state_t;

    // Number of bits needed to encode values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first requester at or after ptr,
// wrapping past NREQ-1 back to 0.
module rr_pick import arb_pkg::*; #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    any,
    output logic [$clog2(NREQ)-1:0] winner
);

    localparam int PW = $clog2(NREQ);

    logic          w_found;
    logic [PW:0]   w_idx;
    logic [PW-1:0] w_winner;

    // Scan NREQ positions starting at ptr; ptr is always below NREQ so one
    // conditional subtraction suffices for the wrap.
    always_comb begin
        w_found  = 1'b0;
        w_idx    = {(PW+1){1'b0}};
        w_winner = {PW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(NREQ)) begin
                w_idx = w_idx - (PW+1)'(NREQ);
            end else begin
                w_idx = w_idx;
            end
            if (!w_found && req[w_idx[PW-1:0]]) begin
                w_winner = w_idx[PW-1:0];
                w_found  = 1'b1;
            end else begin
                w_found  = w_found;
            end
        end
    end

    assign any    = |req;
    assign winner = w_winner;

endmodule : rr_pick

// File: rtl/rr_arb_sched.sv
// Round-robin arbiter for one shared resource: rotating priority, explicit
// release via done, and tenure-bounded preemption when others are waiting.
module rr_arb_sched import arb_pkg::*; #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         done,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    busy,
    output logic                    preempt
);

    localparam int PW = $clog2(NREQ);
    localparam int TW = clog2(MAX_HOLD + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
    localparam logic [TW-1:0] HOLD_MAX = TW'(MAX_HOLD);

    state_t          r_state,   w_state_nxt;
    logic [PW-1:0]   r_ptr,     w_ptr_nxt;
    logic [TW-1:0]   r_tenure,  w_tenure_nxt;
    logic [NREQ-1:0] r_gnt,     w_gnt_nxt;
    logic [PW-1:0]   r_gnt_id,  w_gnt_id_nxt;
    logic            r_busy;
    logic            r_preempt, w_preempt_nxt;

    logic            w_any;
    logic [PW-1:0]   w_winner;
    logic [NREQ-1:0] w_hold_mask;
    logic [PW-1:0]   w_after_hold;
    logic            w_release;
    logic            w_others;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .any    (w_any),
        .winner (w_winner)
    );

    assign w_hold_mask  = NREQ'(1) << r_gnt_id;
    assign w_after_hold = (r_gnt_id == LAST_IDX) ? {PW{1'b0}} : (r_gnt_id + PW'(1));
    assign w_release    = !req[r_gnt_id] || done[r_gnt_id];
    assign w_others     = |(req & ~w_hold_mask);

    // Next-state, pointer, tenure and output decode; release has priority
    // over preemption so a done in the expiry cycle never flags preempt.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_tenure_nxt  = r_tenure;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_preempt_nxt = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (w_any) begin
                    w_state_nxt  = ST_GNT;
                    w_gnt_nxt    = NREQ'(1) << w_winner;
                    w_gnt_id_nxt = w_winner;
                    w_tenure_nxt = TW'(1);
                end else begin
                    w_state_nxt  = ST_IDLE;
                    w_gnt_nxt    = {NREQ{1'b0}};
                end
            end
            ST_GNT: begin
                if (w_release) begin
                    w_state_nxt   = ST_GAP;
                    w_gnt_nxt     = {NREQ{1'b0}};
                    w_ptr_nxt     = w_after_hold;
                end else if ((r_tenure == HOLD_MAX) && w_others) begin
                    w_state_nxt   = ST_GAP;
                    w_gnt_nxt     = {NREQ{1'b0}};
                    w_ptr_nxt     = w_after_hold;
                    w_preempt_nxt = 1'b1;
                end else if (r_tenure != HOLD_MAX) begin
                    w_tenure_nxt  = r_tenure + TW'(1);
                end else begin
                    w_tenure_nxt  = r_tenure;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = {NREQ{1'b0}};
            end
        endcase
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= {PW{1'b0}};
            r_tenure  <= {TW{1'b0}};
            r_gnt     <= {NREQ{1'b0}};
            r_gnt_id  <= {PW{1'b0}};
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_tenure  <= w_tenure_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_busy    <= (w_state_nxt == ST_GNT);
            r_preempt <= w_preempt_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign preempt = r_preempt;

endmodule : rr_arb_sched

// File: tb/tb_rr_arb_sched.sv
// Directed self-checking bench for rr_arb_sched with NREQ=4, MAX_HOLD=8.
module tb_rr_arb_sched;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       preempt;

    int n_cmp;
    int n_err;

    rr_arb_sched #(.NREQ(4), .MAX_HOLD(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_gnt(input string tag, input logic [3:0] eg, input logic eb, input logic ep);
        check_val({tag, ".gnt"},     32'(gnt),     32'(eg));
        check_val({tag, ".busy"},    32'(busy),    32'(eb));
        check_val({tag, ".preempt"}, 32'(preempt), 32'(ep));
    endtask

    task automatic do_reset();
        tick();
        req   = 4'b0000;
        done  = 4'b0000;
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        req   = 4'b0000;
        done  = 4'b0000;

        // Reset state, then a single request from requester 2
        #12;
        check_gnt("rst", 4'b0000, 1'b0, 1'b0);
        check_val("rst.id", 32'(gnt_id), 32'd0);
        #10;
        reset = 1'b1;
        tick();
        req = 4'b0100;
        tick();
        check_gnt("single", 4'b0100, 1'b1, 1'b0);
        check_val("single.id", 32'(gnt_id), 32'd2);

        // Fairness: grant order 0,1,2,3,0 with a gap between holders
        do_reset();
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_gnt("fair.g1", 4'b0001 << (i % 4), 1'b1, 1'b0);
            check_val("fair.id", 32'(gnt_id), 32'(i % 4));
            tick();
            check_gnt("fair.g2", 4'b0001 << (i % 4), 1'b1, 1'b0);
            done = 4'b0001 << (i % 4);
            tick();
            done = 4'b0000;
            check_gnt("fair.gap", 4'b0000, 1'b0, 1'b0);
            check_val("fair.gapid", 32'(gnt_id), 32'(i % 4));
            tick();
        end

        // Preemption between two persistent requesters
        do_reset();
        req = 4'b0011;
        tick();
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 8; j++) begin
                check_gnt("pre.hold", (r == 1) ? 4'b0010 : 4'b0001, 1'b1, 1'b0);
                tick();
            end
            check_gnt("pre.gap", 4'b0000, 1'b0, 1'b1);
            tick();
        end

        // Sole requester keeps the grant; tenure saturated so a newcomer preempts at once
        do_reset();
        req = 4'b0001;
        tick();
        for (int j = 0; j < 30; j++) begin
            check_gnt("sole", 4'b0001, 1'b1, 1'b0);
            tick();
        end
        check_gnt("sole.end", 4'b0001, 1'b1, 1'b0);
        req = 4'b0011;
        tick();
        check_gnt("sole.sat", 4'b0000, 1'b0, 1'b1);
        tick();
        check_gnt("sole.next", 4'b0010, 1'b1, 1'b0);

        // Holder 1 drops req; next search starts from 2
        do_reset();
        req = 4'b0010;
        tick();
        check_gnt("drop.g", 4'b0010, 1'b1, 1'b0);
        req = 4'b1101;
        tick();
        check_gnt("drop.gap", 4'b0000, 1'b0, 1'b0);
        tick();
        check_gnt("drop.next", 4'b0100, 1'b1, 1'b0);
        check_val("drop.id", 32'(gnt_id), 32'd2);

        // done coincides with tenure expiry: plain release, no preempt
        do_reset();
        req = 4'b0011;
        tick();
        for (int j = 0; j < 7; j++) tick();
        check_gnt("sim.last", 4'b0001, 1'b1, 1'b0);
        done = 4'b0001;
        tick();
        done = 4'b0000;
        check_gnt("sim.gap", 4'b0000, 1'b0, 1'b0);
        tick();
        check_gnt("sim.next", 4'b0010, 1'b1, 1'b0);

        // Asynchronous reset mid-grant
        do_reset();
        req = 4'b1000;
        tick();
        check_gnt("ar.g", 4'b1000, 1'b1, 1'b0);
        check_val("ar.id", 32'(gnt_id), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check_gnt("ar.clr", 4'b0000, 1'b0, 1'b0);
        check_val("ar.clrid", 32'(gnt_id), 32'd0);
        #1;
        reset = 1'b1;
        req   = 4'b1001;
        tick();
        check_gnt("ar.win", 4'b0001, 1'b1, 1'b0);
        check_val("ar.winid", 32'(gnt_id), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rr_arb_sched
